// File: rtl/mm_stage_pkg.sv
// Shared definitions for the memory stage: load-op encodings, FSM state codes
// and default datapath widths.
package mm_stage_pkg;

    localparam int MM_DATA_W = 32;
    localparam int MM_REG_AW = 5;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LBU = 3'd1,
        LD_LH  = 3'd2,
        LD_LHU = 3'd3,
        LD_LW  = 3'd4
    } ld_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mm_state_e;

endpackage

// File: rtl/mm_stage_load_align.sv
// Combinational load-data alignment: selects the byte/half addressed by the low
// address bits and sign- or zero-extends it according to the load op.
module mm_load_align
    import mm_stage_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W
)(
    input  logic [2:0]        i_ld_op,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_data
);

    logic signed [7:0]  w_byte;
    logic signed [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_rdata;
        case (i_ld_op)
            LD_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
            LD_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mm_stage.sv
// Dual-lane memory stage: holds the execute results, waits for the lane-1 data
// response, aligns load data and hands results to write-back. Optional
// forwarding outputs are enabled with the MM_FORWARD_EN macro.
module mm_stage
    import mm_stage_pkg::*;
#(
    parameter int DATA_W      = MM_DATA_W,
    parameter int REG_AW      = MM_REG_AW,
    parameter int MAX_DISCARD = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              next_allowin_i,
    input  logic              line1_pre_to_now_valid_i,
    input  logic              line2_pre_to_now_valid_i,
    output logic              now_allowin_o,
    output logic              line1_now_to_next_valid_o,
    output logic              line2_now_to_next_valid_o,
    input  logic              excep_flush_i,
    input  logic              line1_mem_req_i,
    input  logic              line1_load_i,
    input  logic [2:0]        line1_ld_op_i,
    input  logic [1:0]        line1_addr_lo_i,
    input  logic              line1_we_i,
    input  logic              line2_we_i,
    input  logic [REG_AW-1:0] line1_wdest_i,
    input  logic [REG_AW-1:0] line2_wdest_i,
    input  logic [DATA_W-1:0] line1_result_i,
    input  logic [DATA_W-1:0] line2_result_i,
    input  logic              data_sram_data_ok_i,
    input  logic [DATA_W-1:0] data_sram_rdata_i,
    output logic              line1_we_o,
    output logic              line2_we_o,
    output logic [REG_AW-1:0] line1_wdest_o,
    output logic [REG_AW-1:0] line2_wdest_o,
    output logic [DATA_W-1:0] line1_wdata_o,
    output logic [DATA_W-1:0] line2_wdata_o,
`ifdef MM_FORWARD_EN
    output logic [REG_AW+DATA_W+1:0] line1_fwd_o,
    output logic [REG_AW+DATA_W+1:0] line2_fwd_o,
`endif
    output logic              mm_busy_o
);

    localparam int DC_W = $clog2(MAX_DISCARD + 1);

    function automatic logic [DC_W-1:0] sat_inc(input logic [DC_W-1:0] v);
        return (v == DC_W'(MAX_DISCARD)) ? v : v + DC_W'(1);
    endfunction

    mm_state_e         r_state;
    logic [DC_W-1:0]   r_discard;
    logic [DATA_W-1:0] r_hold_data;

    logic              r_l1_vld_p1;
    logic              r_l1_we_p1;
    logic              r_l1_mem_req_p1;
    logic              r_l1_load_p1;
    logic [2:0]        r_l1_ld_op_p1;
    logic [1:0]        r_l1_addr_lo_p1;
    logic [REG_AW-1:0] r_l1_wdest_p1;
    logic [DATA_W-1:0] r_l1_result_p1;

    logic              r_l2_vld_p1;
    logic              r_l2_we_p1;
    logic [REG_AW-1:0] r_l2_wdest_p1;
    logic [DATA_W-1:0] r_l2_result_p1;

    logic              w_wait;
    logic              w_discarding;
    logic              w_resp;
    logic              w_ready;
    logic              w_allowin;
    logic              w_load;
    logic [DATA_W-1:0] w_l1_raw;
    logic [DATA_W-1:0] w_l1_ld_data;

    assign w_wait       = (r_state == ST_WAIT);
    assign w_discarding = (r_discard != '0);
    assign w_resp       = w_wait & data_sram_data_ok_i & ~w_discarding;
    assign w_ready      = ~w_wait | w_resp;
    // A new lane-1 request must not see responses still owed to flushed ones.
    assign w_allowin    = (~(r_l1_vld_p1 | r_l2_vld_p1) | (w_ready & next_allowin_i))
                          & ~(w_discarding & line1_mem_req_i);
    assign w_load       = w_allowin & ~excep_flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (excep_flush_i) begin
            r_state <= ST_IDLE;
        end else if (w_load) begin
            r_state <= (line1_pre_to_now_valid_i & line1_mem_req_i) ? ST_WAIT : ST_IDLE;
        end else if (w_resp) begin
            r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_discard <= '0;
        end else if (excep_flush_i & w_wait & ~data_sram_data_ok_i) begin
            r_discard <= sat_inc(r_discard);
        end else if (data_sram_data_ok_i & w_discarding) begin
            r_discard <= r_discard - DC_W'(1);
        end
    end

    // Response is kept here so write-back may stall after data_ok.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_data <= '0;
        end else if (w_resp) begin
            r_hold_data <= data_sram_rdata_i;
        end
    end

    // ---- stage register: execute -> memory (p1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l1_vld_p1 <= 1'b0;
            r_l2_vld_p1 <= 1'b0;
        end else if (excep_flush_i) begin
            r_l1_vld_p1 <= 1'b0;
            r_l2_vld_p1 <= 1'b0;
        end else if (w_allowin) begin
            r_l1_vld_p1 <= line1_pre_to_now_valid_i;
            r_l2_vld_p1 <= line2_pre_to_now_valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l1_we_p1      <= 1'b0;
            r_l1_mem_req_p1 <= 1'b0;
            r_l1_load_p1    <= 1'b0;
            r_l1_ld_op_p1   <= '0;
            r_l1_addr_lo_p1 <= '0;
            r_l1_wdest_p1   <= '0;
            r_l1_result_p1  <= '0;
        end else if (w_load & line1_pre_to_now_valid_i) begin
            r_l1_we_p1      <= line1_we_i;
            r_l1_mem_req_p1 <= line1_mem_req_i;
            r_l1_load_p1    <= line1_load_i;
            r_l1_ld_op_p1   <= line1_ld_op_i;
            r_l1_addr_lo_p1 <= line1_addr_lo_i;
            r_l1_wdest_p1   <= line1_wdest_i;
            r_l1_result_p1  <= line1_result_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l2_we_p1     <= 1'b0;
            r_l2_wdest_p1  <= '0;
            r_l2_result_p1 <= '0;
        end else if (w_load & line2_pre_to_now_valid_i) begin
            r_l2_we_p1     <= line2_we_i;
            r_l2_wdest_p1  <= line2_wdest_i;
            r_l2_result_p1 <= line2_result_i;
        end
    end

    // ---- memory -> write-back outputs ----
    assign w_l1_raw = w_wait ? data_sram_rdata_i : r_hold_data;

    mm_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_ld_op   (r_l1_ld_op_p1),
        .i_addr_lo (r_l1_addr_lo_p1),
        .i_rdata   (w_l1_raw),
        .o_data    (w_l1_ld_data)
    );

    assign now_allowin_o             = w_allowin;
    assign line1_now_to_next_valid_o = r_l1_vld_p1 & w_ready;
    assign line2_now_to_next_valid_o = r_l2_vld_p1 & w_ready;
    assign line1_we_o                = r_l1_we_p1;
    assign line2_we_o                = r_l2_we_p1;
    assign line1_wdest_o             = r_l1_wdest_p1;
    assign line2_wdest_o             = r_l2_wdest_p1;
    assign line1_wdata_o             = (r_l1_mem_req_p1 & r_l1_load_p1) ? w_l1_ld_data
                                                                         : r_l1_result_p1;
    assign line2_wdata_o             = r_l2_result_p1;
    assign mm_busy_o                 = w_wait | w_discarding;

`ifdef MM_FORWARD_EN
    assign line1_fwd_o = {r_l1_vld_p1 & r_l1_we_p1, r_l1_wdest_p1, line1_wdata_o, w_ready};
    assign line2_fwd_o = {r_l2_vld_p1 & r_l2_we_p1, r_l2_wdest_p1, line2_wdata_o, 1'b1};
`endif

endmodule

// File: tb/tb_mm_stage.sv
// Directed self-checking bench for mm_stage (default build, forwarding disabled).
module tb_mm_stage;

    logic        clk;
    logic        rst;
    logic        next_allowin;
    logic        l1_pv, l2_pv;
    logic        allowin, v1, v2;
    logic        flush;
    logic        l1_mem_req, l1_load;
    logic [2:0]  l1_ld_op;
    logic [1:0]  l1_addr_lo;
    logic        l1_we, l2_we;
    logic [4:0]  l1_wdest, l2_wdest;
    logic [31:0] l1_result, l2_result;
    logic        data_ok;
    logic [31:0] rdata;
    logic        we1_o, we2_o;
    logic [4:0]  wdest1_o, wdest2_o;
    logic [31:0] wdata1_o, wdata2_o;
    logic        busy;

    int checks;
    int failures;

    mm_stage dut (
        .clk                       (clk),
        .rst                       (rst),
        .next_allowin_i            (next_allowin),
        .line1_pre_to_now_valid_i  (l1_pv),
        .line2_pre_to_now_valid_i  (l2_pv),
        .now_allowin_o             (allowin),
        .line1_now_to_next_valid_o (v1),
        .line2_now_to_next_valid_o (v2),
        .excep_flush_i             (flush),
        .line1_mem_req_i           (l1_mem_req),
        .line1_load_i              (l1_load),
        .line1_ld_op_i             (l1_ld_op),
        .line1_addr_lo_i           (l1_addr_lo),
        .line1_we_i                (l1_we),
        .line2_we_i                (l2_we),
        .line1_wdest_i             (l1_wdest),
        .line2_wdest_i             (l2_wdest),
        .line1_result_i            (l1_result),
        .line2_result_i            (l2_result),
        .data_sram_data_ok_i       (data_ok),
        .data_sram_rdata_i         (rdata),
        .line1_we_o                (we1_o),
        .line2_we_o                (we2_o),
        .line1_wdest_o             (wdest1_o),
        .line2_wdest_o             (wdest2_o),
        .line1_wdata_o             (wdata1_o),
        .line2_wdata_o             (wdata2_o),
        .mm_busy_o                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        next_allowin = 1'b1;
        l1_pv = 1'b0; l2_pv = 1'b0; flush = 1'b0;
        l1_mem_req = 1'b0; l1_load = 1'b0; l1_ld_op = 3'd0; l1_addr_lo = 2'd0;
        l1_we = 1'b0; l2_we = 1'b0; l1_wdest = 5'd0; l2_wdest = 5'd0;
        l1_result = 32'h0; l2_result = 32'h0;
        data_ok = 1'b0; rdata = 32'h0;
    endtask

    task automatic offer_l1(input logic mem, input logic ld, input logic [2:0] op,
                            input logic [1:0] lo, input logic [4:0] wd, input logic [31:0] res);
        l1_pv = 1'b1; l1_mem_req = mem; l1_load = ld; l1_ld_op = op;
        l1_addr_lo = lo; l1_we = 1'b1; l1_wdest = wd; l1_result = res;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr();
        repeat (2) cyc();
        @(negedge clk);
        checks++; if (allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", allowin); end
        checks++; if ({v1, v2} !== 2'b00) begin failures++; $display("FAIL reset_valids got=%b exp=00", {v1, v2}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({wdata1_o, wdata2_o} !== 64'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", {wdata1_o, wdata2_o}); end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_lb_sign();
        offer_l1(1'b1, 1'b1, 3'd0, 2'd3, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (allowin !== 1'b1) begin failures++; $display("FAIL lb_allowin got=%b exp=1", allowin); end
        cyc();
        clr();
        @(negedge clk);
        checks++; if ({v1, busy} !== 2'b01) begin failures++; $display("FAIL lb_wait got v1,busy=%b exp=01", {v1, busy}); end
        cyc();
        data_ok = 1'b1; rdata = 32'h80FF_1234;
        @(negedge clk);
        checks++; if (v1 !== 1'b1) begin failures++; $display("FAIL lb_valid got=%b exp=1", v1); end
        checks++; if (wdata1_o !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_wdata got=%h exp=ffffff80", wdata1_o); end
        checks++; if (wdest1_o !== 5'd5) begin failures++; $display("FAIL lb_wdest got=%0d exp=5", wdest1_o); end
        cyc();
        clr();
        @(negedge clk);
        checks++; if ({v1, busy} !== 2'b00) begin failures++; $display("FAIL lb_after got v1,busy=%b exp=00", {v1, busy}); end
        cyc();
    endtask

    task automatic test_lhu_hold();
        int retired;
        retired = 0;
        offer_l1(1'b1, 1'b1, 3'd3, 2'd2, 5'd7, 32'h0);
        cyc();
        clr();
        next_allowin = 1'b0;
        data_ok = 1'b1; rdata = 32'h8001_0000;
        @(negedge clk);
        if (v1 && next_allowin) retired++;
        checks++; if ({v1, wdata1_o} !== {1'b1, 32'h0000_8001}) begin failures++; $display("FAIL lhu_resp got v=%b d=%h exp v=1 d=00008001", v1, wdata1_o); end
        cyc();
        data_ok = 1'b0; rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (v1 && next_allowin) retired++;
            checks++; if ({v1, wdata1_o} !== {1'b1, 32'h0000_8001}) begin failures++; $display("FAIL lhu_hold%0d got v=%b d=%h exp v=1 d=00008001", k, v1, wdata1_o); end
            cyc();
        end
        next_allowin = 1'b1;
        @(negedge clk);
        if (v1 && next_allowin) retired++;
        checks++; if ({v1, wdata1_o} !== {1'b1, 32'h0000_8001}) begin failures++; $display("FAIL lhu_release got v=%b d=%h exp v=1 d=00008001", v1, wdata1_o); end
        cyc();
        @(negedge clk);
        if (v1 && next_allowin) retired++;
        checks++; if (retired !== 1) begin failures++; $display("FAIL lhu_retire_count got=%0d exp=1", retired); end
        cyc();
        clr();
    endtask

    task automatic test_store();
        offer_l1(1'b1, 1'b0, 3'd4, 2'd0, 5'd9, 32'h0000_ABCD);
        cyc();
        clr();
        @(negedge clk);
        checks++; if ({v1, busy} !== 2'b01) begin failures++; $display("FAIL st_wait got v1,busy=%b exp=01", {v1, busy}); end
        cyc();
        data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if ({v1, wdata1_o} !== {1'b1, 32'h0000_ABCD}) begin failures++; $display("FAIL st_done got v=%b d=%h exp v=1 d=0000abcd", v1, wdata1_o); end
        cyc();
        clr();
    endtask

    task automatic test_dual_lane();
        int seen;
        seen = 0;
        offer_l1(1'b1, 1'b1, 3'd4, 2'd0, 5'd2, 32'h0);
        l2_pv = 1'b1; l2_we = 1'b1; l2_wdest = 5'd3; l2_result = 32'h5;
        cyc();
        clr();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (v1 || v2) seen++;
            cyc();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL dual_early got=%0d exp=0", seen); end
        data_ok = 1'b1; rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if ({v1, v2} !== 2'b11) begin failures++; $display("FAIL dual_valids got=%b exp=11", {v1, v2}); end
        checks++; if (wdata2_o !== 32'h5) begin failures++; $display("FAIL dual_l2_wdata got=%h exp=00000005", wdata2_o); end
        checks++; if (wdata1_o !== 32'hCAFE_F00D) begin failures++; $display("FAIL dual_l1_wdata got=%h exp=cafef00d", wdata1_o); end
        checks++; if ({we2_o, wdest2_o} !== {1'b1, 5'd3}) begin failures++; $display("FAIL dual_l2_dest got=%b/%0d exp=1/3", we2_o, wdest2_o); end
        cyc();
        clr();
        @(negedge clk);
        checks++; if ({v1, v2} !== 2'b00) begin failures++; $display("FAIL dual_after got=%b exp=00", {v1, v2}); end
        cyc();
    endtask

    task automatic test_flush_discard();
        offer_l1(1'b1, 1'b1, 3'd4, 2'd0, 5'd4, 32'h0);
        cyc();
        clr();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL fl_flush_v1 got=%b exp=0", v1); end
        cyc();
        flush = 1'b0;
        data_ok = 1'b1; rdata = 32'hBAD0_BAD0;
        offer_l1(1'b1, 1'b1, 3'd4, 2'd0, 5'd6, 32'h0);
        @(negedge clk);
        checks++; if ({v1, busy, allowin} !== 3'b010) begin failures++; $display("FAIL fl_stale got v1,busy,allowin=%b exp=010", {v1, busy, allowin}); end
        cyc();
        data_ok = 1'b0; rdata = 32'h0;
        @(negedge clk);
        checks++; if ({busy, allowin} !== 2'b01) begin failures++; $display("FAIL fl_drained got busy,allowin=%b exp=01", {busy, allowin}); end
        cyc();
        clr();
        @(negedge clk);
        checks++; if ({v1, busy} !== 2'b01) begin failures++; $display("FAIL fl_new_wait got v1,busy=%b exp=01", {v1, busy}); end
        cyc();
        data_ok = 1'b1; rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if ({v1, wdata1_o, wdest1_o} !== {1'b1, 32'h1234_5678, 5'd6}) begin failures++; $display("FAIL fl_new_data got v=%b d=%h w=%0d exp v=1 d=12345678 w=6", v1, wdata1_o, wdest1_o); end
        cyc();
        clr();
    endtask

    task automatic test_flush_priority();
        offer_l1(1'b0, 1'b0, 3'd0, 2'd0, 5'd1, 32'h77);
        l2_pv = 1'b1; l2_we = 1'b1; l2_result = 32'h88;
        flush = 1'b1;
        cyc();
        clr();
        @(negedge clk);
        checks++; if ({v1, v2} !== 2'b00) begin failures++; $display("FAIL flush_prio got=%b exp=00", {v1, v2}); end
        cyc();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            offer_l1(1'b0, 1'b0, 3'd0, 2'd0, 5'(i + 1), 32'h100 + i);
            l2_pv = 1'b1; l2_we = 1'b1; l2_result = 32'h200 + i;
            @(negedge clk);
            checks++; if (allowin !== 1'b1) begin failures++; $display("FAIL b2b_allowin%0d got=%b exp=1", i, allowin); end
            if (i > 0) begin
                checks++;
                if ({v1, v2, wdata1_o, wdata2_o} !== {2'b11, 32'h100 + i - 1, 32'h200 + i - 1}) begin
                    failures++;
                    $display("FAIL b2b_pair%0d got v=%b%b d1=%h d2=%h exp v=11 d1=%h d2=%h", i, v1, v2, wdata1_o, wdata2_o, 32'h100 + i - 1, 32'h200 + i - 1);
                end
            end
            cyc();
        end
        clr();
        @(negedge clk);
        checks++; if ({v1, v2, wdata1_o, wdata2_o} !== {2'b11, 32'h103, 32'h203}) begin failures++; $display("FAIL b2b_last got v=%b%b d1=%h d2=%h exp v=11 d1=103 d2=203", v1, v2, wdata1_o, wdata2_o); end
        cyc();
        @(negedge clk);
        checks++; if ({v1, v2} !== 2'b00) begin failures++; $display("FAIL b2b_drain got=%b exp=00", {v1, v2}); end
        cyc();
    endtask

    task automatic test_async_reset();
        offer_l1(1'b1, 1'b1, 3'd4, 2'd0, 5'd31, 32'h0);
        cyc();
        clr();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_pre_busy got=%b exp=1", busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({v1, v2, busy, we1_o} !== 4'b0000) begin failures++; $display("FAIL ar_ctrl got v1,v2,busy,we=%b exp=0000", {v1, v2, busy, we1_o}); end
        checks++; if ({wdest1_o, wdata1_o} !== 37'h0) begin failures++; $display("FAIL ar_data got w=%0d d=%h exp 0/0", wdest1_o, wdata1_o); end
        checks++; if (allowin !== 1'b1) begin failures++; $display("FAIL ar_allowin got=%b exp=1", allowin); end
        cyc();
        rst = 1'b0;
        data_ok = 1'b1; rdata = 32'h1111_1111;
        @(negedge clk);
        checks++; if ({v1, busy} !== 2'b00) begin failures++; $display("FAIL ar_idle got v1,busy=%b exp=00", {v1, busy}); end
        cyc();
        clr();
        @(negedge clk);
        checks++; if ({busy, allowin} !== 2'b01) begin failures++; $display("FAIL ar_post got busy,allowin=%b exp=01", {busy, allowin}); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_lb_sign();
        test_lhu_hold();
        test_store();
        test_dual_lane();
        test_flush_discard();
        test_flush_priority();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_stage.md
Name: mm_stage

Overview:
- Dual-lane memory stage directly downstream of the execute stage.
- Latches both lanes' execute results into an internal pipeline register.
- For a lane-1 load/store whose request was accepted in execute, waits for the data-SRAM response (data_ok), then aligns and extends load data.
- Presents write-back results to the write-back stage under valid/allowin handshake; supports exception flush with stale-response discard.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
MAX_DISCARD, 3, max stale responses tracked after flush (counter saturates)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
next_allowin_i  in  1  write-back stage can accept
line1_pre_to_now_valid_i  in  1  execute lane-1 offering
line2_pre_to_now_valid_i  in  1  execute lane-2 offering
now_allowin_o  out  1  this stage accepts new pair
line1_now_to_next_valid_o  out  1  lane-1 result valid to write-back
line2_now_to_next_valid_o  out  1  lane-2 result valid to write-back
excep_flush_i  in  1  exception flush
line1_mem_req_i  in  1  lane-1 data request accepted (addr_ok) in execute
line1_load_i  in  1  lane-1 request is load (0 = store)
line1_ld_op_i  in  3  0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw
line1_addr_lo_i  in  2  low address bits
line1_we_i / line2_we_i  in  1  register write enable
line1_wdest_i / line2_wdest_i  in  REG_AW  destination register
line1_result_i / line2_result_i  in  DATA_W  ALU result
data_sram_data_ok_i  in  1  data response strobe
data_sram_rdata_i  in  DATA_W  load data
line1_we_o / line2_we_o  out  1  write enable to write-back
line1_wdest_o / line2_wdest_o  out  REG_AW  destination
line1_wdata_o / line2_wdata_o  out  DATA_W  final write data
mm_busy_o  out  1  stage holds valid instruction(s) awaiting data_ok

Behaviour:
- Reset: all valids 0, state IDLE, discard counter 0, all data outputs 0, mm_busy_o 0, now_allowin_o 1.
- Register load: when now_allowin_o and not flush, lane valids <= pre_to_now_valid inputs; payload captured when the corresponding lane valid is set.
- FSM, one per stage: IDLE (no pending response) and WAIT (lane-1 mem request pending).
- IDLE -> WAIT on load with line1_valid & line1_mem_req_i; WAIT -> IDLE on data_ok with discard counter 0.
- Completion: ready = ~WAIT, or WAIT with data_ok in that cycle (zero-bubble response).
- now_to_next_valid = lane valid & ready; now_allowin_o = ~(line1_valid | line2_valid) | (ready & next_allowin_i).
- Lanes retire together; lane 2 never overtakes lane 1.
- Load data: byte/half selected by addr_lo; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through. Store data_ok only completes the wait; wdata = result.
- Response buffering: a data_ok arriving while next_allowin_i = 0 is latched into a hold register; ready stays 1 until retirement.
- Flush: clears both valids and returns FSM to IDLE. If in WAIT without data_ok that cycle, discard counter += 1 (saturating at MAX_DISCARD); each later data_ok with counter > 0 decrements it and is ignored.
- Flush takes priority over a simultaneous load of a new instruction.
- mm_busy_o = WAIT | discard counter != 0; now_allowin_o is held 0 while the counter != 0 and the incoming lane 1 has mem_req.
- Misaligned addresses are not checked here (execute stage raises ALE).

Optional Feature:
MM_FORWARD_EN: when defined, adds outputs line1_fwd_o / line2_fwd_o, each {valid_we, wdest, wdata, data_ready}, driven combinationally from the stage register; data_ready = 0 for lane 1 while in WAIT without data_ok.
When undefined, these ports do not exist and no forwarding logic is synthesized.

Decomposition:
- Shared package/header: ld_op encodings, FSM state codes, DATA_W/REG_AW constants.
- One natural sub-module: mm_load_align (combinational ld_op/addr_lo/rdata -> extended word).

Test Plan:
- lb at addr_lo=3, rdata=0x80FF_1234, data_ok two cycles after entry -> wdata 0xFFFF_FF80; valid asserted in the data_ok cycle.
- lhu at addr_lo=2, rdata=0x8001_0000 -> wdata 0x0000_8001; next_allowin_i=0 for 3 cycles after data_ok -> output held stable, one retirement.
- Lane-2 add (result 0x5) paired with lane-1 lw waiting 4 cycles -> both valids rise in the same cycle; lane-2 wdata 0x5.
- Flush while in WAIT, stale data_ok next cycle, then new lw whose data_ok returns 0x1234_5678 -> stale response ignored; wdata 0x1234_5678.
- Back-to-back non-memory pairs with next_allowin_i=1 -> one pair retires per cycle; now_allowin_o stays 1.
- Assert rst mid-WAIT -> all outputs 0 immediately (asynchronous); FSM IDLE; discard counter 0.
